// File: rtl/order_msg_scheduler_pkg.sv
// Shared types and widths for the order message scheduler.
// Covers message op codes, scheduler FSM states and a saturating counter helper.
package order_msg_scheduler_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_DEL  = 2'b10,
        OP_EXEC = 2'b11
    } msgOpType;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } schedStateType;

    localparam int REF_W    = 64;
    localparam int LOCATE_W = 16;
    localparam int PRICE_W  = 32;
    localparam int SHARES_W = 32;
    localparam int STAT_W   = 32;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/order_msg_scheduler_inflight_window.sv
// Tracks reference numbers issued within the last DEPTH cycles.
// A probe hit means the engine's order map has not yet absorbed that reference.
module inflight_window
    import order_msg_scheduler_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REF_W-1:0] push_ref,
    input  logic [REF_W-1:0] probe_ref,
    output logic             hit,
    output logic             non_empty
);

    logic [DEPTH-1:0] valid;
    logic [REF_W-1:0] refs [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                refs[i] <= '0;
            end
        end else begin
            valid[0] <= push;
            refs[0]  <= push_ref;
            for (int i = 1; i < DEPTH; i++) begin
                valid[i] <= valid[i-1];
                refs[i]  <= refs[i-1];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (refs[i] == probe_ref)) begin
                hit = 1'b1;
            end
        end
    end

    assign non_empty = |valid;

endmodule

// File: rtl/order_msg_scheduler.sv
// Issues parsed add/delete/execute messages to the order book engine, holding back refs still in flight.
// Define ORDER_SCHED_STATS_EN to add saturating issue/stall/drop counters.
module order_msg_scheduler
    import order_msg_scheduler_pkg::*;
#(
    parameter int ENGINE_LATENCY = 3
) (
    input  logic                clkIn,
    input  logic                rstIn,
    input  logic                msgValidIn,
    output logic                msgReadyOut,
    input  logic [1:0]          msgOpIn,
    input  logic [REF_W-1:0]    refNumIn,
    input  logic [LOCATE_W-1:0] locateIn,
    input  logic [PRICE_W-1:0]  priceIn,
    input  logic [SHARES_W-1:0] sharesIn,
    input  logic                buySellIn,
    input  logic                haltIn,
    output logic                addValidOut,
    output logic                delValidOut,
    output logic                execValidOut,
    output logic [REF_W-1:0]    refNumOut,
    output logic [LOCATE_W-1:0] locateOut,
    output logic [PRICE_W-1:0]  priceOut,
    output logic [SHARES_W-1:0] sharesOut,
    output logic                buySellOut,
    output logic                busyOut
`ifdef ORDER_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]   issueCountOut,
    output logic [STAT_W-1:0]   stallCountOut,
    output logic [STAT_W-1:0]   dropCountOut
`endif
);

    schedStateType state, state_nxt;

    logic                hold_valid;
    msgOpType            hold_op;
    logic [REF_W-1:0]    hold_ref;
    logic [LOCATE_W-1:0] hold_locate;
    logic [PRICE_W-1:0]  hold_price;
    logic [SHARES_W-1:0] hold_shares;
    logic                hold_buy_sell;

    msgOpType msg_op;
    logic     win_hit;
    logic     win_non_empty;
    logic     hazard;
    logic     issue_now;
    logic     accept;
    logic     take;

    inflight_window #(
        .DEPTH(ENGINE_LATENCY)
    ) u_window (
        .clk       (clkIn),
        .rst       (rstIn),
        .push      (issue_now),
        .push_ref  (hold_ref),
        .probe_ref (hold_ref),
        .hit       (win_hit),
        .non_empty (win_non_empty)
    );

    assign msg_op      = msgOpType'(msgOpIn);
    assign hazard      = hold_valid && win_hit;
    assign issue_now   = hold_valid && !win_hit && !haltIn;
    assign msgReadyOut = !hold_valid || issue_now;
    assign accept      = msgValidIn && msgReadyOut;
    assign take        = accept && (msg_op != OP_NONE);

    // NONE ops are consumed by the handshake but never occupy the holding register.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            hold_valid    <= 1'b0;
            hold_op       <= OP_NONE;
            hold_ref      <= '0;
            hold_locate   <= '0;
            hold_price    <= '0;
            hold_shares   <= '0;
            hold_buy_sell <= 1'b0;
        end else if (take) begin
            hold_valid    <= 1'b1;
            hold_op       <= msg_op;
            hold_ref      <= refNumIn;
            hold_locate   <= locateIn;
            hold_price    <= priceIn;
            hold_shares   <= sharesIn;
            hold_buy_sell <= buySellIn;
        end else if (issue_now) begin
            hold_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            addValidOut  <= 1'b0;
            delValidOut  <= 1'b0;
            execValidOut <= 1'b0;
            refNumOut    <= '0;
            locateOut    <= '0;
            priceOut     <= '0;
            sharesOut    <= '0;
            buySellOut   <= 1'b0;
            busyOut      <= 1'b0;
        end else begin
            addValidOut  <= issue_now && (hold_op == OP_ADD);
            delValidOut  <= issue_now && (hold_op == OP_DEL);
            execValidOut <= issue_now && (hold_op == OP_EXEC);
            busyOut      <= hold_valid || win_non_empty;
            if (issue_now) begin
                refNumOut  <= hold_ref;
                locateOut  <= hold_locate;
                priceOut   <= hold_price;
                sharesOut  <= hold_shares;
                buySellOut <= hold_buy_sell;
            end
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (haltIn) begin
                    state_nxt = ST_HALT;
                end else if (hazard) begin
                    state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                if (haltIn) begin
                    state_nxt = ST_HALT;
                end else if (!hazard) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!haltIn) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

`ifdef ORDER_SCHED_STATS_EN
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            issueCountOut <= '0;
            stallCountOut <= '0;
            dropCountOut  <= '0;
        end else begin
            if (issue_now) begin
                issueCountOut <= sat_inc(issueCountOut);
            end
            if (state == ST_STALL) begin
                stallCountOut <= sat_inc(stallCountOut);
            end
            if (accept && (msg_op == OP_NONE)) begin
                dropCountOut <= sat_inc(dropCountOut);
            end
        end
    end
`endif

endmodule

// File: tb/tb_order_msg_scheduler.sv
// Directed self-checking bench for order_msg_scheduler at ENGINE_LATENCY = 3.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_order_msg_scheduler;

    logic        clkIn = 1'b0;
    logic        rstIn;
    logic        msgValidIn;
    logic        msgReadyOut;
    logic [1:0]  msgOpIn;
    logic [63:0] refNumIn;
    logic [15:0] locateIn;
    logic [31:0] priceIn;
    logic [31:0] sharesIn;
    logic        buySellIn;
    logic        haltIn;
    logic        addValidOut;
    logic        delValidOut;
    logic        execValidOut;
    logic [63:0] refNumOut;
    logic [15:0] locateOut;
    logic [31:0] priceOut;
    logic [31:0] sharesOut;
    logic        buySellOut;
    logic        busyOut;
`ifdef ORDER_SCHED_STATS_EN
    logic [31:0] issueCountOut;
    logic [31:0] stallCountOut;
    logic [31:0] dropCountOut;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    order_msg_scheduler #(
        .ENGINE_LATENCY(3)
    ) dut (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .msgValidIn   (msgValidIn),
        .msgReadyOut  (msgReadyOut),
        .msgOpIn      (msgOpIn),
        .refNumIn     (refNumIn),
        .locateIn     (locateIn),
        .priceIn      (priceIn),
        .sharesIn     (sharesIn),
        .buySellIn    (buySellIn),
        .haltIn       (haltIn),
        .addValidOut  (addValidOut),
        .delValidOut  (delValidOut),
        .execValidOut (execValidOut),
        .refNumOut    (refNumOut),
        .locateOut    (locateOut),
        .priceOut     (priceOut),
        .sharesOut    (sharesOut),
        .buySellOut   (buySellOut),
        .busyOut      (busyOut)
`ifdef ORDER_SCHED_STATS_EN
        ,
        .issueCountOut(issueCountOut),
        .stallCountOut(stallCountOut),
        .dropCountOut (dropCountOut)
`endif
    );

    always #5 clkIn = ~clkIn;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic idle(input int n);
        msgValidIn = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive(input logic [1:0] op, input logic [63:0] ref_num, input logic [31:0] price);
        msgValidIn = 1'b1;
        msgOpIn    = op;
        refNumIn   = ref_num;
        locateIn   = 16'h0007;
        priceIn    = price;
        sharesIn   = 32'd100;
        buySellIn  = 1'b1;
    endtask

    // Steps n edges and reports the first edge (1-based) at which each pulse appears, 0 if never.
    task automatic step_find(input int n, output int add_at, output int del_at, output int exec_at);
        add_at  = 0;
        del_at  = 0;
        exec_at = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            chk_eq("pulse_onehot", 64'(addValidOut + delValidOut + execValidOut > 1), 64'd0);
            if (addValidOut && add_at == 0) add_at = i;
            if (delValidOut && del_at == 0) del_at = i;
            if (execValidOut && exec_at == 0) exec_at = i;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_at, d_at, e_at;

        rstIn      = 1'b1;
        msgValidIn = 1'b0;
        msgOpIn    = 2'b00;
        refNumIn   = '0;
        locateIn   = '0;
        priceIn    = '0;
        sharesIn   = '0;
        buySellIn  = 1'b0;
        haltIn     = 1'b0;
        #2;
        chk_eq("rst_ready", msgReadyOut, 1);
        chk_eq("rst_pulses", {addValidOut, delValidOut, execValidOut}, 0);
        chk_eq("rst_ref", refNumOut, 0);
        chk_eq("rst_busy", busyOut, 0);
`ifdef ORDER_SCHED_STATS_EN
        chk_eq("rst_issue_cnt", issueCountOut, 0);
`endif
        tick();
        rstIn = 1'b0;

        // single add: two-cycle latency, fields passed through
        drive(2'b01, 64'h10, 32'h1234);
        tick();
        msgValidIn = 1'b0;
        chk_eq("t1_ready", msgReadyOut, 1);
        chk_eq("t1_add_early", addValidOut, 0);
        tick();
        chk_eq("t1_add", addValidOut, 1);
        chk_eq("t1_ref", refNumOut, 64'h10);
        chk_eq("t1_price", priceOut, 32'h1234);
        chk_eq("t1_shares", sharesOut, 32'd100);
        chk_eq("t1_locate", locateOut, 16'h0007);
        chk_eq("t1_side", buySellOut, 1);
        tick();
        chk_eq("t1_add_single", addValidOut, 0);
        chk_eq("t1_busy", busyOut, 1);
        idle(4);
        chk_eq("t1_busy_fall", busyOut, 0);

        // add then delete to the same ref: delete waits out the engine latency
        drive(2'b01, 64'h10, 32'h1111);
        tick();
        drive(2'b10, 64'h10, 32'h2222);
        tick();
        msgValidIn = 1'b0;
        chk_eq("t2_add", addValidOut, 1);
        chk_eq("t2_stall_ready", msgReadyOut, 0);
        step_find(8, a_at, d_at, e_at);
        chk_eq("t2_del_gap", d_at, 4);
        chk_eq("t2_no_readd", a_at, 0);
        chk_eq("t2_del_ref", refNumOut, 64'h10);
        chk_eq("t2_del_price", priceOut, 32'h2222);
`ifdef ORDER_SCHED_STATS_EN
        chk_eq("t2_stall_cnt", stallCountOut, 3);
        chk_eq("t2_issue_cnt", issueCountOut, 3);
`endif

        // ten distinct adds stream at one per cycle
        for (int i = 1; i <= 10; i++) begin
            drive(2'b01, 64'(i), 32'(i * 100));
            tick();
            chk_eq("t3_ready", msgReadyOut, 1);
            chk_eq("t3_add", addValidOut, 64'(i > 1));
            if (i > 1) begin
                chk_eq("t3_ref", refNumOut, 64'(i - 1));
                chk_eq("t3_price", priceOut, 64'((i - 1) * 100));
            end
        end
        msgValidIn = 1'b0;
        tick();
        chk_eq("t3_add_last", addValidOut, 1);
        chk_eq("t3_ref_last", refNumOut, 64'd10);
        tick();
        chk_eq("t3_add_done", addValidOut, 0);
        idle(4);

        // halt holds an exec for five cycles
        haltIn = 1'b1;
        drive(2'b11, 64'h22, 32'h3333);
        tick();
        msgValidIn = 1'b0;
        chk_eq("t4_ready_halt", msgReadyOut, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_eq("t4_no_exec", execValidOut, 0);
            chk_eq("t4_ready_halt", msgReadyOut, 0);
        end
        haltIn = 1'b0;
        #1;
        chk_eq("t4_ready_release", msgReadyOut, 1);
        tick();
        chk_eq("t4_exec", execValidOut, 1);
        chk_eq("t4_exec_ref", refNumOut, 64'h22);
        idle(5);

        // NONE is accepted and dropped
        chk_eq("t5_busy_before", busyOut, 0);
        drive(2'b00, 64'h55, 32'h4444);
        #1;
        chk_eq("t5_ready", msgReadyOut, 1);
        tick();
        msgValidIn = 1'b0;
        chk_eq("t5_no_pulse", {addValidOut, delValidOut, execValidOut}, 0);
        chk_eq("t5_busy", busyOut, 0);
        tick();
        chk_eq("t5_busy_after", busyOut, 0);
        chk_eq("t5_no_pulse_after", {addValidOut, delValidOut, execValidOut}, 0);
        chk_eq("t5_ref_hold", refNumOut, 64'h22);
`ifdef ORDER_SCHED_STATS_EN
        chk_eq("t5_drop_cnt", dropCountOut, 1);
        chk_eq("t5_issue_cnt", issueCountOut, 14);
`endif

        // reset in the middle of a stall discards the held delete
        drive(2'b01, 64'h40, 32'h5555);
        tick();
        drive(2'b10, 64'h40, 32'h6666);
        tick();
        msgValidIn = 1'b0;
        chk_eq("t6_add", addValidOut, 1);
        tick();
        tick();
        chk_eq("t6_stalled", msgReadyOut, 0);
        #2;
        rstIn = 1'b1;
        #1;
        chk_eq("t6_rst_pulses", {addValidOut, delValidOut, execValidOut}, 0);
        chk_eq("t6_rst_ref", refNumOut, 0);
        chk_eq("t6_rst_price", priceOut, 0);
        chk_eq("t6_rst_busy", busyOut, 0);
        chk_eq("t6_rst_ready", msgReadyOut, 1);
`ifdef ORDER_SCHED_STATS_EN
        chk_eq("t6_rst_stall_cnt", stallCountOut, 0);
`endif
        tick();
        rstIn = 1'b0;
        step_find(8, a_at, d_at, e_at);
        chk_eq("t6_no_del", d_at, 0);
        chk_eq("t6_no_add", a_at, 0);
        chk_eq("t6_busy", busyOut, 0);
        chk_eq("t6_ready", msgReadyOut, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/order_msg_scheduler.md
# order_msg_scheduler

Sequences parsed market messages into the order book engine. Accepts one add/delete/execute message per cycle over a valid/ready handshake and issues it as a single-cycle add, delete or execute pulse. Holds back any message whose reference number is still in flight inside the engine, so an order map read never sees a stale entry. Sits between the message parser and the order book engine.

## Interface
- ENGINE_LATENCY, default 3: cycles from an issue pulse until the engine's order map update is visible; range 1..8.
- clkIn  input  1  clock.
- rstIn  input  1  reset; one clock; reset is asynchronous and active-high.
- msgValidIn  input  1  message present.
- msgReadyOut  output  1  scheduler can accept.
- msgOpIn  input  2  msgOpType: 2'b01 ADD, 2'b10 DEL, 2'b11 EXEC, 2'b00 NONE.
- refNumIn  input  64  order reference number.
- locateIn  input  16  stock locate.
- priceIn  input  32  price.
- sharesIn  input  32  shares.
- buySellIn  input  1  side.
- haltIn  input  1  suspend issuing, level-sensitive.
- addValidOut, delValidOut, execValidOut  output  1 each  one-cycle issue pulses; at most one high per cycle.
- refNumOut, locateOut, priceOut, sharesOut, buySellOut  output  64/16/32/32/1  issued message fields.
- busyOut  output  1  holding register or in-flight window non-empty.

## Operation
- Holding register: one entry (holdValid plus fields). msgReadyOut = !holdValid || issueNow.
- Accept: on msgValidIn && msgReadyOut at edge k, load the holding register.
- NONE ops are accepted and discarded. They never enter the holding register or the window.
- In-flight window: ENGINE_LATENCY entries of {valid, refNum}. Shifts one place per cycle; the oldest entry drops out. On an issue, the issued refNum enters at the head.
- Hazard: holdValid and the held refNum equals the refNum of any valid window entry. Applies to all op types.
- issueNow = holdValid && !hazard && !haltIn.
- FSM, 3 states:
  - RUN: issuing or idle. Go to HALT on haltIn; go to STALL if holdValid && hazard.
  - STALL: holding is blocked by a hazard. Go to RUN when the hazard clears; haltIn takes priority and goes to HALT.
  - HALT: no issues. The window keeps draining. Go to RUN when haltIn falls.
- On issueNow, fields and the matching op pulse are registered at the next edge. With no issue, output fields hold their last value and all pulses are 0.
- Simultaneous issue and accept in the same cycle is allowed; this gives full throughput of 1 message per cycle.
- The window shifts every cycle, so the worst-case stall is ENGINE_LATENCY cycles.
- Reset values: msgReadyOut 1 once out of reset, all pulses 0, all fields 0, busyOut 0. The holding register, window and FSM go to RUN/empty. Reset mid-stall drops the held message.

## Timing
- Latency: accept at edge k, then the issue pulse is high in the cycle after edge k+1 (2 cycles) when there is no hazard and no halt.
- Back-to-back messages to the same refNum: the second pulse follows the first by ENGINE_LATENCY+1 cycles.
- A haltIn assertion sampled at edge k blocks the issue at edge k+1.
- busyOut is registered and falls the cycle after both the holding register and the window are empty.

## Configuration
- ORDER_SCHED_STATS_EN defined: adds three 32-bit outputs, all reset to 0 and saturating at all-ones:
  - issueCountOut: issued messages.
  - stallCountOut: cycles in STALL.
  - dropCountOut: NONE ops discarded.
- ORDER_SCHED_STATS_EN undefined: these ports and counters are absent. Functional behaviour is identical.

## Structure
- Shared package pkg holds the msgOpType enum (NONE/ADD/DEL/EXEC) and schedStateType (RUN/STALL/HALT).
- One sub-module, inflight_window: shift register plus parallel comparator. Inputs are push/refNum and probe refNum; outputs are hit and nonEmpty.

## Test plan
- ADD ref 0x10 accepted at edge 0: addValidOut high after edge 1 with refNumOut 0x10, priceOut/sharesOut passed through, and msgReadyOut stays 1.
- ADD 0x10 then DEL 0x10 back-to-back, ENGINE_LATENCY=3: delValidOut fires 4 cycles after addValidOut, the FSM spends 3 cycles in STALL, and stallCountOut reads 3 with the macro defined.
- Ten consecutive adds with distinct refs 1..10: one pulse per cycle, in order, and no stall.
- haltIn held for 5 cycles with EXEC 0x22 held: no pulse and msgReadyOut 0. execValidOut fires 1 cycle after haltIn falls.
- msgOpIn NONE with valid: accepted, no pulse, busyOut unchanged, and dropCountOut increments.
- rstIn asserted asynchronously during STALL: all outputs go to their reset values immediately, busyOut is 0 afterwards, and the held message never issues.
